// File: rtl/legv8_enc_pkg.sv
// ---------------------------------------------------------------------------
// legv8_enc_pkg
// Shared definitions for the LEGv8 instruction encoder: the mnemonic-level
// operation enum, the opcode field constants (the same bit patterns the
// single-cycle control decoder matches on), field widths and the packed
// command record handed from the encoder top level to the word formatter.
// ---------------------------------------------------------------------------
package legv8_enc_pkg;

   localparam int OP_W      = 4;
   localparam int REG_W     = 5;
   localparam int IMM_W     = 26;
   localparam int HW_W      = 2;
   localparam int WORD_W    = 32;
   localparam int ADDR_W    = 64;
   localparam int ERR_CNT_W = 8;

   // Immediate field widths inside the encoded word.
   localparam int ALU_IMM_W = 12;
   localparam int MOV_IMM_W = 16;
   localparam int CB_IMM_W  = 19;
   localparam int DT_IMM_W  = 9;

   // Byte stride between consecutive instruction words.
   localparam logic [ADDR_W-1:0] WORD_BYTES = 64'd4;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 4'd0,
      OP_ORR  = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_ADDI = 4'd4,
      OP_SUBI = 4'd5,
      OP_MOVZ = 4'd6,
      OP_B    = 4'd7,
      OP_CBZ  = 4'd8,
      OP_LDUR = 4'd9,
      OP_STUR = 4'd10
   } op_e;

   // R-type opcodes (11 bits).
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   // I-type opcodes (10 bits).
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   // IM-type opcode (9 bits).
   localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
   // B-type opcode (6 bits).
   localparam logic [5:0]  OPC_B    = 6'b000101;
   // CB-type opcode (8 bits).
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   // D-type opcodes (11 bits).
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;

   // op is kept as raw bits: codes 11..15 must reach the formatter so it can
   // flag them illegal.
   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rn;
      logic [REG_W-1:0] rm;
      logic [IMM_W-1:0] imm;
      logic [HW_W-1:0]  hw;
   } enc_cmd_t;

endpackage

// File: rtl/legv8_enc_format.sv
// ---------------------------------------------------------------------------
// legv8_enc_format
// Purely combinational formatter: packs one mnemonic-level command into the
// 32-bit LEGv8 machine word and classifies it.
//
// Ports:
//   cmd      in   enc_cmd_t  operation, register fields, immediate, MOVZ hw
//   word     out  32         encoded instruction (zero when op is illegal)
//   legal    out  1          op is one of the eleven supported operations
//   in_range out  1          immediate fits its field
//
// Build option: define ENC_RANGE_CHECK_EN to reject immediates that do not
// fit their field. Without it in_range is constant 1 and oversized
// immediates are silently truncated into the word.
// ---------------------------------------------------------------------------
module legv8_enc_format
   import legv8_enc_pkg::*;
(
   input  enc_cmd_t            cmd,
   output logic [WORD_W-1:0]   word,
   output logic                legal,
   output logic                in_range
);

   // NOTE: every output of an always_comb gets a default before the case so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (cmd.op)
         OP_AND:  word = {OPC_AND, cmd.rm, 6'd0, cmd.rn, cmd.rd};
         OP_ORR:  word = {OPC_ORR, cmd.rm, 6'd0, cmd.rn, cmd.rd};
         OP_ADD:  word = {OPC_ADD, cmd.rm, 6'd0, cmd.rn, cmd.rd};
         OP_SUB:  word = {OPC_SUB, cmd.rm, 6'd0, cmd.rn, cmd.rd};
         OP_ADDI: word = {OPC_ADDI, cmd.imm[ALU_IMM_W-1:0], cmd.rn, cmd.rd};
         OP_SUBI: word = {OPC_SUBI, cmd.imm[ALU_IMM_W-1:0], cmd.rn, cmd.rd};
         OP_MOVZ: word = {OPC_MOVZ, cmd.hw, cmd.imm[MOV_IMM_W-1:0], cmd.rd};
         OP_B:    word = {OPC_B, cmd.imm};
         // Rt travels in the rd field for CBZ and the load/store pair.
         OP_CBZ:  word = {OPC_CBZ, cmd.imm[CB_IMM_W-1:0], cmd.rd};
         OP_LDUR: word = {OPC_LDUR, cmd.imm[DT_IMM_W-1:0], 2'b00, cmd.rn, cmd.rd};
         OP_STUR: word = {OPC_STUR, cmd.imm[DT_IMM_W-1:0], 2'b00, cmd.rn, cmd.rd};
         default: legal = 1'b0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   // Unsigned fields need all bits above the field clear; signed fields need
   // all bits above the field to repeat the field's sign bit.
   always_comb begin
      in_range = 1'b1;
      case (cmd.op)
         OP_ADDI, OP_SUBI: in_range = (cmd.imm[IMM_W-1:ALU_IMM_W] == '0);
         OP_MOVZ:          in_range = (cmd.imm[IMM_W-1:MOV_IMM_W] == '0);
         OP_CBZ:           in_range = (cmd.imm[IMM_W-1:CB_IMM_W-1] == '0)
                                   || (cmd.imm[IMM_W-1:CB_IMM_W-1] == '1);
         OP_LDUR, OP_STUR: in_range = (cmd.imm[IMM_W-1:DT_IMM_W-1] == '0)
                                   || (cmd.imm[IMM_W-1:DT_IMM_W-1] == '1);
         default:          in_range = 1'b1;
      endcase
   end
`else
   assign in_range = 1'b1;
`endif

endmodule

// File: rtl/legv8_insn_encoder.sv
// ---------------------------------------------------------------------------
// legv8_insn_encoder
// Sequential LEGv8 instruction encoder/loader. Accepts mnemonic-level
// commands over a valid/ready stream, encodes each into a 32-bit machine
// word and presents it, with an auto-incrementing byte address, on a
// valid/ready write port towards instruction memory.
//
// Ports:
//   CLK        in   1   clock, rising edge
//   resetl     in   1   asynchronous active-low reset
//   start      in   1   pulse; in IDLE loads the write address and begins a program
//   base_addr  in   64  byte address of the first word
//   cmd_valid  in   1   command offered
//   cmd_ready  out  1   command accepted when both high
//   cmd_op     in   4   operation code (11..15 illegal)
//   cmd_rd     in   5   Rd / Rt
//   cmd_rn     in   5   Rn
//   cmd_rm     in   5   Rm
//   cmd_imm    in   26  immediate, interpreted per operation
//   cmd_hw     in   2   MOVZ shift select
//   cmd_last   in   1   final command of the program
//   wr_valid   out  1   encoded word present
//   wr_ready   in   1   memory takes the word when both high
//   wr_addr    out  64  byte address of wr_word
//   wr_word    out  32  encoded instruction
//   done       out  1   one-cycle pulse once the last word has been written
//   err        out  1   sticky: some command was rejected; cleared by start
//   err_count  out  8   rejected commands, saturating at 255; cleared by start
//
// Build option: ENC_RANGE_CHECK_EN (see legv8_enc_format) enables rejection
// of out-of-range immediates.
// ---------------------------------------------------------------------------
module legv8_insn_encoder
   import legv8_enc_pkg::*;
(
   input  logic                  CLK,
   input  logic                  resetl,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [OP_W-1:0]       cmd_op,
   input  logic [REG_W-1:0]      cmd_rd,
   input  logic [REG_W-1:0]      cmd_rn,
   input  logic [REG_W-1:0]      cmd_rm,
   input  logic [IMM_W-1:0]      cmd_imm,
   input  logic [HW_W-1:0]       cmd_hw,
   input  logic                  cmd_last,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [WORD_W-1:0]     wr_word,
   output logic                  done,
   output logic                  err,
   output logic [ERR_CNT_W-1:0]  err_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e              state;
   state_e              state_next;
   enc_cmd_t            cmd;
   logic [WORD_W-1:0]   fmt_word;
   logic                fmt_legal;
   logic                fmt_in_range;
   logic                accept;
   logic                emit;
   logic                reject;
   logic                wr_fire;
   logic                start_load;

   assign cmd = '{op: cmd_op, rd: cmd_rd, rn: cmd_rn, rm: cmd_rm,
                  imm: cmd_imm, hw: cmd_hw};

   legv8_enc_format u_format (
      .cmd      (cmd),
      .word     (fmt_word),
      .legal    (fmt_legal),
      .in_range (fmt_in_range)
   );

   // A new command may enter while the output register is empty or is being
   // drained in this same cycle, which gives one word per cycle.
   assign cmd_ready  = (state == RUN) && (!wr_valid || wr_ready);
   assign accept     = cmd_valid && cmd_ready;
   assign emit       = accept && fmt_legal && fmt_in_range;
   assign reject     = accept && !(fmt_legal && fmt_in_range);
   assign wr_fire    = wr_valid && wr_ready;
   assign start_load = (state == IDLE) && start;

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      done       = 1'b0;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (accept && cmd_last) state_next = DRAIN;
         DRAIN: begin
            if (!wr_valid) begin
               state_next = IDLE;
               done       = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output register. wr_addr always names the slot of the pending word, or
   // the next free slot when nothing is pending, so it only moves on a write
   // handshake; a rejected command therefore leaves it untouched. IDLE never
   // holds a pending word, so the start load cannot collide with a handshake.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         wr_valid <= 1'b0;
         wr_word  <= '0;
         wr_addr  <= '0;
      end else begin
         if (emit) begin
            wr_valid <= 1'b1;
            wr_word  <= fmt_word;
         end else if (wr_fire) begin
            wr_valid <= 1'b0;
         end

         if (start_load) begin
            wr_addr <= base_addr;
         end else if (wr_fire) begin
            wr_addr <= wr_addr + WORD_BYTES;
         end
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         err       <= 1'b0;
         err_count <= '0;
      end else if (start_load) begin
         err       <= 1'b0;
         err_count <= '0;
      end else if (reject) begin
         err <= 1'b1;
         if (err_count != '1) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_legv8_insn_encoder.sv
// ---------------------------------------------------------------------------
// tb_legv8_insn_encoder
// Self-checking bench for legv8_insn_encoder. Stimulus tasks push the
// hand-computed expected {address, word} of every command that should be
// written into a scoreboard queue; an independent monitor pops and compares
// on every write handshake. Expectations for oversized immediates follow
// ENC_RANGE_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_legv8_insn_encoder;
   import legv8_enc_pkg::*;

   logic          CLK = 1'b0;
   logic          resetl;
   logic          start;
   logic [63:0]   base_addr;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_op;
   logic [4:0]    cmd_rd;
   logic [4:0]    cmd_rn;
   logic [4:0]    cmd_rm;
   logic [25:0]   cmd_imm;
   logic [1:0]    cmd_hw;
   logic          cmd_last;
   logic          wr_valid;
   logic          wr_ready;
   logic [63:0]   wr_addr;
   logic [31:0]   wr_word;
   logic          done;
   logic          err;
   logic [7:0]    err_count;

   legv8_insn_encoder dut (
      .CLK       (CLK),
      .resetl    (resetl),
      .start     (start),
      .base_addr (base_addr),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_rd    (cmd_rd),
      .cmd_rn    (cmd_rn),
      .cmd_rm    (cmd_rm),
      .cmd_imm   (cmd_imm),
      .cmd_hw    (cmd_hw),
      .cmd_last  (cmd_last),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_word   (wr_word),
      .done      (done),
      .err       (err),
      .err_count (err_count)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] word;
      bit          b2b;   // must be written the cycle after the previous word
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks      = 0;
   int   errors      = 0;
   int   last_wr_cyc = -100;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: one scoreboard pop per write handshake.
   always @(negedge CLK) begin
      if (resetl === 1'b1 && wr_valid === 1'b1 && wr_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h word 0x%0h, expected no write",
                     wr_addr, wr_word);
         end else begin
            mon_e = sb.pop_front();
            check("wr_addr", wr_addr, mon_e.addr);
            check("wr_word", {32'd0, wr_word}, {32'd0, mon_e.word});
            if (mon_e.b2b) check("back_to_back", 64'(cyc), 64'(last_wr_cyc + 1));
         end
         last_wr_cyc = cyc;
      end
   end

   task automatic expect_word(input logic [63:0] addr, input logic [31:0] word, input bit b2b);
      sb.push_back('{addr, word, b2b});
   endtask

   task automatic do_start(input logic [63:0] base);
      start     = 1'b1;
      base_addr = base;
      @(posedge CLK); #1;
      start     = 1'b0;
   endtask

   task automatic send_cmd(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw,
                           input logic last);
      int n = 0;
      cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
      cmd_imm = imm; cmd_hw = hw; cmd_last = last;
      cmd_valid = 1'b1;
      @(negedge CLK);
      while (cmd_ready !== 1'b1 && n < 50) begin
         n++;
         @(negedge CLK);
      end
      if (cmd_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL cmd_accept_timeout: got cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
      end
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
   endtask

   task automatic wait_done(input string name, input bit right_after_write);
      int n = 0;
      @(negedge CLK);
      while (done !== 1'b1 && n < 20) begin
         n++;
         @(negedge CLK);
      end
      check({name, "_done_seen"}, {63'd0, done}, 64'd1);
      if (right_after_write) check({name, "_done_cycle"}, 64'(cyc), 64'(last_wr_cyc + 1));
      @(negedge CLK);
      check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
      @(posedge CLK); #1;
   endtask

   logic       exp_err;
   logic [7:0] exp_cnt;
   logic [63:0] exp_next;

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetl = 1'b0; start = 1'b0; base_addr = '0; cmd_valid = 1'b0;
      cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
      cmd_hw = '0; cmd_last = 1'b0; wr_ready = 1'b1;

      // Reset state.
      @(negedge CLK); @(negedge CLK);
      check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check("rst_wr_valid",  {63'd0, wr_valid},  64'd0);
      check("rst_wr_addr",   wr_addr,            64'd0);
      check("rst_wr_word",   {32'd0, wr_word},   64'd0);
      check("rst_done",      {63'd0, done},      64'd0);
      check("rst_err",       {63'd0, err},       64'd0);
      check("rst_err_count", {56'd0, err_count}, 64'd0);
      @(posedge CLK); #1;
      resetl = 1'b1;
      @(posedge CLK); #1;

      // 1: ADDI X1,X2,#10 as a one-word program at 0x100.
      do_start(64'h100);
      expect_word(64'h100, 32'h91002841, 1'b0);
      send_cmd(OP_ADDI, 5'd1, 5'd2, 5'd0, 26'd10, 2'd0, 1'b1);
      wait_done("addi", 1'b1);

      // 2: back-to-back ADD, LDUR, CBZ from address 0.
      do_start(64'h0);
      expect_word(64'h0, 32'h8B020023, 1'b0);
      expect_word(64'h4, 32'hF85F80A4, 1'b1);
      expect_word(64'h8, 32'hB4FFFFC7, 1'b1);
      send_cmd(OP_ADD,  5'd3, 5'd1, 5'd2, 26'd0,        2'd0, 1'b0);
      send_cmd(OP_LDUR, 5'd4, 5'd5, 5'd0, 26'h3FFFFF8,  2'd0, 1'b0);
      send_cmd(OP_CBZ,  5'd7, 5'd0, 5'd0, 26'h3FFFFFE,  2'd0, 1'b1);
      wait_done("b2b", 1'b1);

      // 3: MOVZ stalled for three cycles, then B.
      do_start(64'h200);
      expect_word(64'h200, 32'hD2A24689, 1'b0);
      expect_word(64'h204, 32'h14000003, 1'b1);
      send_cmd(OP_MOVZ, 5'd9, 5'd0, 5'd0, 26'h1234, 2'd1, 1'b0);
      wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("stall_wr_valid",  {63'd0, wr_valid},  64'd1);
         check("stall_wr_word",   {32'd0, wr_word},   64'hD2A24689);
         check("stall_wr_addr",   wr_addr,            64'h200);
         check("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      end
      @(posedge CLK); #1;
      wr_ready = 1'b1;
      send_cmd(OP_B, 5'd0, 5'd0, 5'd0, 26'd3, 2'd0, 1'b1);
      wait_done("stall", 1'b1);

      // 4: ADDI X0,X0,#5000 (immediate too wide for 12 bits).
      do_start(64'h300);
`ifdef ENC_RANGE_CHECK_EN
      exp_err = 1'b1; exp_cnt = 8'd1; exp_next = 64'h300;
`else
      exp_err = 1'b0; exp_cnt = 8'd0; exp_next = 64'h304;
      expect_word(64'h300, 32'h910E2000, 1'b0);
`endif
      send_cmd(OP_ADDI, 5'd0, 5'd0, 5'd0, 26'd5000, 2'd0, 1'b1);
      wait_done("range", 1'b0);
      check("range_err",       {63'd0, err},       {63'd0, exp_err});
      check("range_err_count", {56'd0, err_count}, {56'd0, exp_cnt});
      check("range_wr_addr",   wr_addr,            exp_next);

      // 5: illegal ops around a legal one; address must not skip.
      do_start(64'h400);
      @(negedge CLK);
      check("start_clears_err",       {63'd0, err},       64'd0);
      check("start_clears_err_count", {56'd0, err_count}, 64'd0);
      @(posedge CLK); #1;
      expect_word(64'h400, 32'h8B020023, 1'b0);
      send_cmd(4'd12, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b0);
      send_cmd(OP_ADD, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0);
      send_cmd(4'd13, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b1);
      wait_done("illegal", 1'b0);
      check("illegal_err",       {63'd0, err},       64'd1);
      check("illegal_err_count", {56'd0, err_count}, 64'd2);
      check("illegal_wr_addr",   wr_addr,            64'h404);

      // 6: err_count saturates at 255.
      do_start(64'h500);
      for (int i = 0; i < 260; i++) begin
         send_cmd(4'd15, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, (i == 259));
      end
      wait_done("saturate", 1'b0);
      check("saturate_err_count", {56'd0, err_count}, 64'd255);

      // 7: reset mid-RUN with a word pending, then a clean restart.
      do_start(64'h600);
      wr_ready = 1'b0;
      send_cmd(4'd14, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b0);
      send_cmd(OP_ADD, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0);
      @(negedge CLK);
      check("pre_abort_wr_valid", {63'd0, wr_valid}, 64'd1);
      #2;
      resetl = 1'b0;
      #1;
      check("abort_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check("abort_wr_valid",  {63'd0, wr_valid},  64'd0);
      check("abort_wr_addr",   wr_addr,            64'd0);
      check("abort_wr_word",   {32'd0, wr_word},   64'd0);
      check("abort_done",      {63'd0, done},      64'd0);
      check("abort_err",       {63'd0, err},       64'd0);
      check("abort_err_count", {56'd0, err_count}, 64'd0);
      @(posedge CLK); #1;
      resetl   = 1'b1;
      wr_ready = 1'b1;
      @(posedge CLK); #1;
      do_start(64'h700);
      expect_word(64'h700, 32'h91002841, 1'b0);
      send_cmd(OP_ADDI, 5'd1, 5'd2, 5'd0, 26'd10, 2'd0, 1'b1);
      wait_done("restart", 1'b1);

      // 8: address wrap plus remaining formats and field boundaries.
      do_start(64'hFFFF_FFFF_FFFF_FFFC);
      expect_word(64'hFFFF_FFFF_FFFF_FFFC, 32'hAA030041, 1'b0);
      expect_word(64'h0, 32'hCB0700C5, 1'b1);
      expect_word(64'h4, 32'hF80FF041, 1'b1);
      expect_word(64'h8, 32'hD13FFC62, 1'b1);
      expect_word(64'hC, 32'h8A1F0000, 1'b1);
      send_cmd(OP_ORR,  5'd1, 5'd2, 5'd3,  26'd0,    2'd0, 1'b0);
      send_cmd(OP_SUB,  5'd5, 5'd6, 5'd7,  26'd0,    2'd0, 1'b0);
      send_cmd(OP_STUR, 5'd1, 5'd2, 5'd0,  26'd255,  2'd0, 1'b0);
      send_cmd(OP_SUBI, 5'd2, 5'd3, 5'd0,  26'd4095, 2'd0, 1'b0);
      send_cmd(OP_AND,  5'd0, 5'd0, 5'd31, 26'd0,    2'd0, 1'b1);
      wait_done("wrap", 1'b1);
      check("wrap_err", {63'd0, err}, 64'd0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
